// File: rtl/alu_pkg.sv
// Shared opcode map and datapath width for the execute-stage ALU.
package alu_pkg;

    localparam int WIDTH  = 16;
    localparam int CODE_W = 5;

    // Arithmetic
    localparam logic [4:0] OP_ADD_S = 5'b00000;
    localparam logic [4:0] OP_ADD_U = 5'b00001;
    localparam logic [4:0] OP_SUB_S = 5'b00010;
    localparam logic [4:0] OP_SUB_U = 5'b00011;
    localparam logic [4:0] OP_INC   = 5'b00100;
    localparam logic [4:0] OP_DEC   = 5'b00101;

    // Bitwise logic
    localparam logic [4:0] OP_AND   = 5'b01000;
    localparam logic [4:0] OP_OR    = 5'b01001;
    localparam logic [4:0] OP_XOR   = 5'b01010;
    localparam logic [4:0] OP_NOT   = 5'b01100;

    // Shifts
    localparam logic [4:0] OP_SLL   = 5'b10000;
    localparam logic [4:0] OP_SRL   = 5'b10001;
    localparam logic [4:0] OP_SLA   = 5'b10010;
    localparam logic [4:0] OP_SRA   = 5'b10011;

    // Signed set-on-condition
    localparam logic [4:0] OP_LE    = 5'b11000;
    localparam logic [4:0] OP_LT    = 5'b11001;
    localparam logic [4:0] OP_GE    = 5'b11010;
    localparam logic [4:0] OP_GT    = 5'b11011;
    localparam logic [4:0] OP_EQ    = 5'b11100;
    localparam logic [4:0] OP_NE    = 5'b11101;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: operands and opcode in, next result and flag out.
module alu_comb
    import alu_pkg::*;
#(
    parameter int W  = alu_pkg::WIDTH,
    parameter int CW = alu_pkg::CODE_W
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [CW-1:0] alu_code,
    output logic [W-1:0]  c_next,
    output logic          ovf_next
);

    localparam int SHW = $clog2(W);

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

    logic [W:0]         sum;
    logic [W:0]         diff;
    logic [SHW-1:0]     shamt;
    logic signed [W-1:0] sra_res;
    logic               lt_s;
    logic               eq;
    logic               add_s_ovf;
    logic               sub_s_ovf;

    // One extra bit on each sum exposes carry (add) and borrow (sub).
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[SHW-1:0];

    assign sra_res = $signed(a) >>> shamt;
    assign lt_s    = $signed(a) < $signed(b);
    assign eq      = (a == b);

    assign add_s_ovf = (a[W-1] == b[W-1]) && (sum[W-1]  != a[W-1]);
    assign sub_s_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);

    always_comb begin
        c_next   = '0;
        ovf_next = 1'b0;
        case (alu_code)
            OP_ADD_S: begin c_next = sum[W-1:0];  ovf_next = add_s_ovf;      end
            OP_ADD_U: begin c_next = sum[W-1:0];  ovf_next = sum[W];         end
            OP_SUB_S: begin c_next = diff[W-1:0]; ovf_next = sub_s_ovf;      end
            OP_SUB_U: begin c_next = diff[W-1:0]; ovf_next = diff[W];        end
            OP_INC:   begin c_next = a + ONE;     ovf_next = (a == MAX_POS); end
            OP_DEC:   begin c_next = a - ONE;     ovf_next = (a == MIN_NEG); end

            OP_AND:   c_next = a & b;
            OP_OR:    c_next = a | b;
            OP_XOR:   c_next = a ^ b;
            OP_NOT:   c_next = ~a;

            OP_SLL,
            OP_SLA:   c_next = a << shamt;
            OP_SRL:   c_next = a >> shamt;
            OP_SRA:   c_next = sra_res;

            OP_LE:    c_next = {{(W-1){1'b0}}, lt_s | eq};
            OP_LT:    c_next = {{(W-1){1'b0}}, lt_s};
            OP_GE:    c_next = {{(W-1){1'b0}}, ~lt_s};
            OP_GT:    c_next = {{(W-1){1'b0}}, ~(lt_s | eq)};
            OP_EQ:    c_next = {{(W-1){1'b0}}, eq};
            OP_NE:    c_next = {{(W-1){1'b0}}, ~eq};

            default: begin
                c_next   = '0;
                ovf_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered execute-stage ALU: one-cycle latency, new op accepted every cycle.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CODE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [CODE_W-1:0] alu_code,
    output logic [WIDTH-1:0]  c,
    output logic              overflow
);

    logic [WIDTH-1:0] c_next;
    logic             ovf_next;

    alu_comb #(
        .W  (WIDTH),
        .CW (CODE_W)
    ) u_comb (
        .a        (a),
        .b        (b),
        .alu_code (alu_code),
        .c_next   (c_next),
        .ovf_next (ovf_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            c        <= '0;
            overflow <= 1'b0;
        end else begin
            c        <= c_next;
            overflow <= ovf_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU with hand-computed expectations.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  alu_code;
    logic [15:0] c;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(16), .CODE_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .alu_code (alu_code),
        .c        (c),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] exp_c, input logic exp_o);
        checks++;
        assert (c === exp_c && overflow === exp_o) else begin
            errors++;
            $error("FAIL %s: c=%h ovf=%b expected c=%h ovf=%b", tag, c, overflow, exp_c, exp_o);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                      input logic [4:0] code, input logic [15:0] exp_c, input logic exp_o);
        @(negedge clk);
        a = va; b = vb; alu_code = code;
        @(posedge clk);
        #1;
        chk(tag, exp_c, exp_o);
    endtask

    initial begin
        rst = 1'b1; a = 16'hFFFF; b = 16'hFFFF; alu_code = 5'b00000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 16'h0000, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_add", 16'hFFFE, 1'b0);

        op("add_s_ovf",   16'h7FFF, 16'h0001, 5'b00000, 16'h8000, 1'b1);
        op("add_u_carry", 16'hFFFF, 16'h0001, 5'b00001, 16'h0000, 1'b1);
        op("add_s_plain", 16'h0000, 16'h0001, 5'b00000, 16'h0001, 1'b0);
        op("add_s_negov", 16'h8000, 16'hFFFF, 5'b00000, 16'h7FFF, 1'b1);

        op("sub_s",       16'h0000, 16'h0001, 5'b00010, 16'hFFFF, 1'b0);
        op("sub_u_borrow",16'h0000, 16'h0001, 5'b00011, 16'hFFFF, 1'b1);
        op("sub_u_plain", 16'h0005, 16'h0003, 5'b00011, 16'h0002, 1'b0);
        op("sub_s_ovf",   16'h8000, 16'h0001, 5'b00010, 16'h7FFF, 1'b1);
        op("inc_ovf",     16'h7FFF, 16'h0000, 5'b00100, 16'h8000, 1'b1);
        op("inc_wrap",    16'hFFFF, 16'h0000, 5'b00100, 16'h0000, 1'b0);
        op("dec_ovf",     16'h8000, 16'h0000, 5'b00101, 16'h7FFF, 1'b1);
        op("dec_wrap",    16'h0000, 16'h0000, 5'b00101, 16'hFFFF, 1'b0);

        op("or",          16'hFF00, 16'h00FF, 5'b01001, 16'hFFFF, 1'b0);
        op("and",         16'hFF00, 16'hFF00, 5'b01000, 16'hFF00, 1'b0);
        op("and_mix",     16'hF0F0, 16'h3C3C, 5'b01000, 16'h3030, 1'b0);
        op("xor",         16'hAAAA, 16'hAAAA, 5'b01010, 16'h0000, 1'b0);
        op("not",         16'hAAAA, 16'h1234, 5'b01100, 16'h5555, 1'b0);

        op("sll",         16'h4924, 16'h0001, 5'b10000, 16'h9248, 1'b0);
        op("srl",         16'h4924, 16'h0001, 5'b10001, 16'h2492, 1'b0);
        op("sla",         16'h4924, 16'h0001, 5'b10010, 16'h9248, 1'b0);
        op("sra_pos",     16'h4924, 16'h0001, 5'b10011, 16'h2492, 1'b0);
        op("sra_neg",     16'h8000, 16'h0003, 5'b10011, 16'hF000, 1'b0);
        op("srl_neg",     16'h8000, 16'h0003, 5'b10001, 16'h1000, 1'b0);
        op("sll_n0",      16'h4924, 16'h0010, 5'b10000, 16'h4924, 1'b0);
        op("sll_n15",     16'h0003, 16'h000F, 5'b10000, 16'h8000, 1'b0);

        op("le_eq",       16'h0001, 16'h0001, 5'b11000, 16'h0001, 1'b0);
        op("lt_eq",       16'h0001, 16'h0001, 5'b11001, 16'h0000, 1'b0);
        op("ge_eq",       16'h0001, 16'h0001, 5'b11010, 16'h0001, 1'b0);
        op("gt_eq",       16'h0001, 16'h0001, 5'b11011, 16'h0000, 1'b0);
        op("eq_eq",       16'h0001, 16'h0001, 5'b11100, 16'h0001, 1'b0);
        op("ne_eq",       16'h0001, 16'h0001, 5'b11101, 16'h0000, 1'b0);
        op("le_lt",       16'h0000, 16'h0001, 5'b11000, 16'h0001, 1'b0);
        op("lt_lt",       16'h0000, 16'h0001, 5'b11001, 16'h0001, 1'b0);
        op("ge_lt",       16'h0000, 16'h0001, 5'b11010, 16'h0000, 1'b0);
        op("gt_lt",       16'h0000, 16'h0001, 5'b11011, 16'h0000, 1'b0);
        op("eq_lt",       16'h0000, 16'h0001, 5'b11100, 16'h0000, 1'b0);
        op("ne_lt",       16'h0000, 16'h0001, 5'b11101, 16'h0001, 1'b0);
        op("lt_signed",   16'hFFFF, 16'h0001, 5'b11001, 16'h0001, 1'b0);
        op("gt_signed",   16'h8000, 16'h7FFF, 5'b11011, 16'h0000, 1'b0);

        op("undef_11111", 16'h1234, 16'h5678, 5'b11111, 16'h0000, 1'b0);
        op("undef_00110", 16'hFFFF, 16'hFFFF, 5'b00110, 16'h0000, 1'b0);

        // Latency: the output must hold until the edge after new inputs appear.
        op("lat_setup",   16'h0002, 16'h0003, 5'b00001, 16'h0005, 1'b0);
        @(negedge clk);
        a = 16'h7FFF; b = 16'h0001; alu_code = 5'b00000;
        #1;
        chk("lat_hold", 16'h0005, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_update", 16'h8000, 1'b1);

        // Reset overrides a live operation, then the stream resumes immediately.
        @(negedge clk);
        rst = 1'b1; a = 16'hFFFF; b = 16'h0001; alu_code = 5'b00001;
        @(posedge clk);
        #1;
        chk("rst_priority", 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release", 16'h0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
